// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction
// fetch and the MEM stage (loads/stores).
//
// Data accesses win arbitration. A starvation counter limits how many data
// grants can be made in a row while fetch is waiting. Each access is run by a
// registered FSM: IDLE -> ACC_IF/ACC_DM -> DONE -> IDLE. The strobes and the
// address are held until mem_ready. Data is returned with a one-cycle done
// pulse. DONE is a one-cycle bubble in which no arbitration takes place.
//
// Optional feature (macro MEM_TIMEOUT_EN): if mem_ready stays low for TIMEOUT
// cycles, the access is aborted. Done pulses with zero data and mem_err pulses
// for one cycle. When the macro is undefined, an access waits indefinitely and
// mem_err is tied to 0.
//
// Ports:
//   clock, reset                rising-edge clock, synchronous active-low reset
//   if_req/if_addr              fetch request (level) and address
//   if_rdata/if_done            fetched word and one-cycle completion pulse
//   dm_readmem/dm_writemem      load / store request (level); both high = store
//   dm_addr/dm_wdata            data address and store data
//   dm_rdata/dm_done            load data and one-cycle completion pulse
//   stall_if/stall_mem          combinational pipeline stall requests
//   mem_addr/mem_wdata          registered memory address / write data
//   mem_rd/mem_wr               registered memory strobes
//   mem_rdata/mem_ready         memory read data and acknowledge
//   mem_err                     one-cycle timeout-abort pulse
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_readmem,
  input  logic              dm_writemem,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM, DONE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              dm_req, grant_dm, complete, abort;

`ifdef MEM_TIMEOUT_EN
  // The abort happens on the TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
`endif

  assign dm_req = dm_readmem | dm_writemem;

  always_comb begin
    // NOTE: every variable gets a default value first, so no path through the
    // case can infer a latch.
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    grant_dm     = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Data wins unless it has used up its run of grants while fetch waits.
        grant_dm = dm_req & ((starve_cnt_q < STARVE_MAX) | ~if_req);
        if (grant_dm) begin
          state_d     = ACC_DM;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wr_d    = dm_writemem;
          mem_rd_d    = ~dm_writemem;  // read+write together is a store
          if (if_req && starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_req) begin
          state_d      = ACC_IF;
          mem_addr_d   = if_addr;
          mem_rd_d     = 1'b1;
          mem_wr_d     = 1'b0;
          starve_cnt_d = '0;
        end
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ACC_IF, ACC_DM: begin
        complete = mem_ready;
`ifdef MEM_TIMEOUT_EN
        if (!mem_ready) begin
          if (wait_cnt_q == WAIT_LAST) abort = 1'b1;
          else                         wait_cnt_d = wait_cnt_q + 8'd1;
        end
        mem_err_d = abort;
`endif
        if (complete || abort) begin
          state_d  = DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == ACC_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = abort ? '0 : mem_rdata;
          end else begin
            dm_done_d  = 1'b1;
            // Stores return zero; mem_wr_q still marks the access kind here.
            dm_rdata_d = (abort || mem_wr_q) ? '0 : mem_rdata;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: synchronous reset is evaluated only at the clock edge; a reset
      // during an access drops it without a done pulse.
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      starve_cnt_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments let all flops sample their _d values
      // from the same edge, independent of statement order.
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err   = mem_err_q;
`else
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A behavioural memory answers the strobes after a programmable number of wait
// states. Expected read data is queued when a request is issued and compared
// when the matching done pulse appears. Scenario tasks check the timing and
// protocol details inline.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_readmem = 1'b0;
  logic        dm_writemem = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall_if, stall_mem;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];
  bit          grant_log[$];   // 1 = fetch completed, 0 = data completed

  logic [31:0] mem_model [logic [31:0]];
  int          ready_delay = 0;
  bit          never_ready = 1'b0;
  int          wcnt = 0;

  mem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .dm_readmem (dm_readmem),
    .dm_writemem(dm_writemem),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: acknowledges after ready_delay strobe cycles.
  always @(negedge clock) begin
    if (mem_rd || mem_wr) begin
      mem_ready = !never_ready && (wcnt >= ready_delay);
      mem_rdata = mem_ready ? mem_value(mem_addr) : 32'hDEAD_DEAD;
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_DEAD;
      wcnt = 0;
    end
  end

  always @(posedge clock) begin
    if (reset && mem_wr && mem_ready) mem_model[mem_addr] = mem_wdata;
  end

  // Scoreboard: pops the expected data on every done pulse.
  always @(negedge clock) begin
    logic [31:0] exp;
    if (if_done === 1'b1) begin
      grant_log.push_back(1'b1);
      checks++;
      if (if_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_if_unexpected: if_done=1 rdata=%h, no fetch outstanding", if_rdata);
      end else begin
        exp = if_exp_q.pop_front();
        if (if_rdata !== exp) begin
          errors++;
          $display("FAIL sb_if_rdata: got %h expected %h", if_rdata, exp);
        end
      end
    end
    if (dm_done === 1'b1) begin
      grant_log.push_back(1'b0);
      checks++;
      if (dm_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_dm_unexpected: dm_done=1 rdata=%h, no data access outstanding", dm_rdata);
      end else begin
        exp = dm_exp_q.pop_front();
        if (dm_rdata !== exp) begin
          errors++;
          $display("FAIL sb_dm_rdata: got %h expected %h", dm_rdata, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    checks++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_rd, mem_wr});
    end
    checks++;
    if ({if_done, dm_done, mem_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {if_done, dm_done, mem_err});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got if=%h dm=%h expected 0", if_rdata, dm_rdata);
    end
    checks++;
    if (dut.starve_cnt_q !== 4'd0) begin
      errors++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt_q);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_fetch();
    mem_model[32'h40] = 32'h8C22_0004;
    ready_delay = 0;
    if_exp_q.push_back(32'h8C22_0004);
    if_req = 1'b1;
    if_addr = 32'h40;
    tick(1);  // cycle 1
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL fetch_strobe: got rd=%b wr=%b addr=%h expected 1 0 00000040", mem_rd, mem_wr, mem_addr);
    end
    checks++;
    if (if_done !== 1'b0 || stall_if !== 1'b1) begin
      errors++; $display("FAIL fetch_cycle1: got done=%b stall=%b expected 0 1", if_done, stall_if);
    end
    tick(1);  // cycle 2
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h8C22_0004 || stall_if !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL fetch_cycle2: got done=%b rdata=%h stall=%b rd=%b expected 1 8c220004 0 0", if_done, if_rdata, stall_if, mem_rd);
    end
    if_req = 1'b0;
    tick(1);
    checks++;
    if (if_done !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse_width: got if_done=%b expected 0", if_done);
    end
    tick(2);
  endtask

  task automatic test_simultaneous();
    bit dm_seen = 0, if_seen = 0, stall_drop = 0;
    mem_model[32'h100] = 32'h0000_BEEF;
    mem_model[32'h44]  = 32'h1111_2222;
    grant_log.delete();
    dm_exp_q.push_back(32'h0000_BEEF);
    if_exp_q.push_back(32'h1111_2222);
    if_req = 1'b1; if_addr = 32'h44;
    dm_readmem = 1'b1; dm_addr = 32'h100;
    tick(1);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL simul_data_first: got rd=%b addr=%h expected 1 00000100", mem_rd, mem_addr);
    end
    for (int c = 0; c < 20 && !dm_seen; c++) begin
      if (stall_if !== 1'b1) stall_drop = 1;
      if (dm_done === 1'b1) begin
        dm_seen = 1;
        dm_readmem = 1'b0;
      end else tick(1);
    end
    checks++;
    if (!dm_seen || stall_drop || if_done !== 1'b0) begin
      errors++; $display("FAIL simul_data_phase: got dm_done_seen=%0d stall_if_dropped=%0d if_done=%b expected 1 0 0", dm_seen, stall_drop, if_done);
    end
    for (int c = 0; c < 20 && !if_seen; c++) begin
      tick(1);
      if (if_done === 1'b1) begin
        if_seen = 1;
        if_req = 1'b0;
      end
    end
    tick(2);
    checks++;
    if (!if_seen || grant_log.size() != 2 || grant_log[0] != 1'b0 || grant_log[1] != 1'b1) begin
      errors++; $display("FAIL simul_order: got if_seen=%0d completions=%0d expected data then fetch", if_seen, grant_log.size());
    end
  endtask

  task automatic test_starvation();
    int dm_cnt = 0;
    bit if_seen = 0, order_ok;
    logic [3:0] sc_at3 = '0, sc_at_if = '1;
    mem_model[32'h300] = 32'h3333_0000;
    mem_model[32'h80]  = 32'h8080_8080;
    grant_log.delete();
    repeat (3) dm_exp_q.push_back(32'h3333_0000);
    if_exp_q.push_back(32'h8080_8080);
    checks++;
    if (dut.starve_cnt_q !== 4'd0) begin
      errors++; $display("FAIL starve_start: got %0d expected 0", dut.starve_cnt_q);
    end
    if_req = 1'b1; if_addr = 32'h80;
    dm_readmem = 1'b1; dm_addr = 32'h300;
    for (int c = 0; c < 40 && !if_seen; c++) begin
      tick(1);
      if (dm_done === 1'b1) begin
        dm_cnt++;
        if (dm_cnt == 3) sc_at3 = dut.starve_cnt_q;
      end
      if (if_done === 1'b1) begin
        if_seen = 1;
        sc_at_if = dut.starve_cnt_q;
        if_req = 1'b0;
        dm_readmem = 1'b0;
      end
    end
    tick(2);
    checks++;
    if (!if_seen || dm_cnt != 3) begin
      errors++; $display("FAIL starve_grants: got data_grants=%0d fetch_seen=%0d expected 3 1", dm_cnt, if_seen);
    end
    checks++;
    if (sc_at3 !== 4'd3 || sc_at_if !== 4'd0) begin
      errors++; $display("FAIL starve_count: got %0d/%0d expected 3/0", sc_at3, sc_at_if);
    end
    order_ok = (grant_log.size() == 4);
    if (order_ok) order_ok = !grant_log[0] && !grant_log[1] && !grant_log[2] && grant_log[3];
    checks++;
    if (!order_ok) begin
      errors++; $display("FAIL starve_order: got %0d completions expected D D D I", grant_log.size());
    end
  endtask

  task automatic test_store_wait();
    int wr_cycles = 0, pulses = 0;
    bit changed = 0;
    ready_delay = 4;
    dm_exp_q.push_back(32'h0);
    dm_writemem = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (mem_wr === 1'b1) begin
        wr_cycles++;
        if (mem_addr !== 32'h200 || mem_wdata !== 32'hCAFE_F00D || mem_rd !== 1'b0) changed = 1;
      end
      if (c == 2) begin
        dm_addr = 32'h999; dm_wdata = 32'h0;  // must be ignored mid-access
      end
      if (dm_done === 1'b1) begin
        pulses++;
        dm_writemem = 1'b0;
      end
    end
    dm_writemem = 1'b0;
    ready_delay = 0;
    checks++;
    if (wr_cycles != 5 || changed) begin
      errors++; $display("FAIL store_hold: got wr_cycles=%0d bus_changed=%0d expected 5 0", wr_cycles, changed);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL store_done_pulse: got %0d pulses expected 1", pulses);
    end
    checks++;
    if (mem_value(32'h200) !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL store_data: got %h expected cafef00d", mem_value(32'h200));
    end
  endtask

  task automatic test_reset_mid();
    bit in_acc = 0;
    int lat = -1;
    never_ready = 1'b1;
    dm_readmem = 1'b1; dm_addr = 32'h100;
    for (int c = 0; c < 10 && !in_acc; c++) begin
      tick(1);
      if (mem_rd === 1'b1) in_acc = 1;
    end
    checks++;
    if (!in_acc) begin
      errors++; $display("FAIL rstmid_grant: got no mem_rd expected access in progress");
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || dm_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: got rd=%b wr=%b done=%b expected 0 0 0", mem_rd, mem_wr, dm_done);
    end
    tick(1);
    never_ready = 1'b0;
    dm_exp_q.push_back(32'h0000_BEEF);
    reset = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick(1);
      if (dm_done === 1'b1) begin
        lat = c;
        dm_readmem = 1'b0;
      end
    end
    dm_readmem = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL rstmid_reserve: got done latency %0d expected 2", lat);
    end
    tick(2);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int rd_cycles = 0;
    bit seen = 0;
    never_ready = 1'b1;
    if_exp_q.push_back(32'h0);
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(1);
      if (mem_rd === 1'b1) rd_cycles++;
      if (mem_err === 1'b1) begin
        seen = 1;
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h0) begin
          errors++; $display("FAIL timeout_done: got done=%b rdata=%h expected 1 0", if_done, if_rdata);
        end
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    never_ready = 1'b0;
    checks++;
    if (!seen || rd_cycles != 15) begin
      errors++; $display("FAIL timeout_wait: got err_seen=%0d wait_cycles=%0d expected 1 15", seen, rd_cycles);
    end
    tick(1);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_err_pulse: got %b expected 0", mem_err);
    end
    tick(2);
  endtask
`else
  task automatic test_timeout();
    bit err_seen = 0, done_seen = 0;
    never_ready = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (mem_err !== 1'b0) err_seen = 1;
      if (if_done === 1'b1) done_seen = 1;
    end
    checks++;
    if (err_seen || done_seen || mem_rd !== 1'b1) begin
      errors++; $display("FAIL no_timeout: got err=%0d done=%0d rd=%b expected 0 0 1", err_seen, done_seen, mem_rd);
    end
    reset = 1'b0;
    if_req = 1'b0;
    tick(2);
    never_ready = 1'b0;
    reset = 1'b1;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_store_wait();
    test_reset_mid();
    test_timeout();
    tick(3);
    checks++;
    if (if_exp_q.size() != 0 || dm_exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d fetch and %0d data results outstanding expected 0 0", if_exp_q.size(), dm_exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
